// File: rtl/program_sequencer_if.sv
// Sequencer-side bundle: control inputs, instruction ROM port and decoder/datapath outputs.
// master = the sequencer, slave = the surrounding ROM/datapath/controller.
interface program_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] im_addr;
  logic [12:0]       im_data;
  logic [4:0]        opcode;
  logic [7:0]        literal;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  modport master (
    input  start, stall, im_data,
    output im_addr, opcode, literal, pc, busy, done
  );

  modport slave (
    output start, stall, im_data,
    input  im_addr, opcode, literal, pc, busy, done
  );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/load/exec sequencer: walks a synchronous ROM from address 0, one opcode per un-stalled EXEC
// cycle (3 cycles/instruction), ends on HALT or at the last address; stall holds EXEC with opcode=NOP.
module program_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [4:0]  HALT_OP = 5'b11111,
  parameter logic [4:0]  NOP_OP  = 5'b11111
) (
  input logic                 clk,
  input logic                 rst,
  program_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] PC_MAX = '1;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [12:0]       ir_q, ir_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = bus.im_data;
        // HALT is retired straight from LOAD, never presented to the decoder
        state_d = (bus.im_data[12:8] == HALT_OP) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (!bus.stall) begin
          if (pc_q == PC_MAX) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.opcode  = NOP_OP;
    bus.literal = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state_q)
      S_FETCH, S_LOAD: bus.busy = 1'b1;
      S_EXEC: begin
        bus.busy    = 1'b1;
        bus.literal = ir_q[7:0];
        bus.opcode  = bus.stall ? NOP_OP : ir_q[12:8];
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.im_addr = pc_q;
  assign bus.pc      = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: per-cycle traces of two instances (8-bit and 2-bit PC)
// compared against hand-derived cycle numbers.
module tb_program_sequencer;
  localparam logic [4:0] NOP = 5'h1F;
  localparam int N = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_sequencer_if #(.ADDR_W(8)) bus8 ();
  program_sequencer_if #(.ADDR_W(2)) bus2 ();

  program_sequencer #(.ADDR_W(8), .HALT_OP(5'h1F), .NOP_OP(5'h1F)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.master)
  );
  program_sequencer #(.ADDR_W(2), .HALT_OP(5'h1F), .NOP_OP(5'h1F)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  logic [12:0] rom8 [256];
  logic [12:0] rom2 [4];

  always_ff @(posedge clk) begin
    bus8.im_data <= rom8[bus8.im_addr];
    bus2.im_data <= rom2[bus2.im_addr];
  end

  logic [4:0] t_op   [N];
  logic [7:0] t_lit  [N];
  logic [7:0] t_pc   [N];
  logic       t_busy [N];
  logic       t_done [N];
  logic [4:0] t2_op  [N];
  logic [7:0] t2_pc  [N];
  logic       t2_done[N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c of the trace is the cycle in which st[c]/sl[c]/rs[c] are applied; cycle 0 = first start.
  task automatic run(input bit which, input logic [63:0] st, input logic [63:0] sl,
                     input logic [63:0] rs);
    for (int c = 0; c < N; c++) begin
      if (which) bus2.start = st[c];
      else       bus8.start = st[c];
      bus8.stall = sl[c];
      bus2.stall = sl[c];
      rst        = rs[c];
      #1;
      t_op[c]    = bus8.opcode;
      t_lit[c]   = bus8.literal;
      t_pc[c]    = bus8.pc;
      t_busy[c]  = bus8.busy;
      t_done[c]  = bus8.done;
      t2_op[c]   = bus2.opcode;
      t2_pc[c]   = {6'd0, bus2.pc};
      t2_done[c] = bus2.done;
      @(posedge clk);
      #1;
    end
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    bus8.stall = 1'b0;
    bus2.stall = 1'b0;
    rst        = 1'b0;
  endtask

  function automatic int count_exec(input bit which);
    int n = 0;
    for (int c = 0; c < N; c++) begin
      if (which ? (t2_op[c] != NOP) : (t_op[c] != NOP)) n++;
    end
    return n;
  endfunction

  function automatic int count_done(input bit which);
    int n = 0;
    for (int c = 0; c < N; c++) begin
      if (which ? t2_done[c] : t_done[c]) n++;
    end
    return n;
  endfunction

  initial begin
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.stall = 1'b0;
    bus2.start = 1'b0;
    bus2.stall = 1'b0;
    for (int i = 0; i < 256; i++) rom8[i] = 13'h1F00;
    rom8[0] = 13'h0005;
    rom8[1] = 13'h0103;
    rom8[2] = 13'h0700;
    rom8[3] = 13'h1F00;
    rom2[0] = 13'h0101;
    rom2[1] = 13'h0202;
    rom2[2] = 13'h0303;
    rom2[3] = 13'h0404;

    repeat (3) @(posedge clk);
    #1;
    check("rst_opcode",  32'(bus8.opcode),  32'(NOP));
    check("rst_literal", 32'(bus8.literal), 32'h0);
    check("rst_pc",      32'(bus8.pc),      32'h0);
    check("rst_im_addr", 32'(bus8.im_addr), 32'h0);
    check("rst_busy",    32'(bus8.busy),    32'h0);
    check("rst_done",    32'(bus8.done),    32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic run: EXEC in cycles 3, 6, 9; HALT at 3 loads in 11, DONE in 12
    run(1'b0, 64'h1, 64'h0, 64'h0);
    check("basic_fetch_busy", 32'(t_busy[1]), 32'h1);
    check("basic_op3",    32'(t_op[3]),   32'h00);
    check("basic_lit3",   32'(t_lit[3]),  32'h05);
    check("basic_lit4",   32'(t_lit[4]),  32'h00);
    check("basic_op6",    32'(t_op[6]),   32'h01);
    check("basic_lit6",   32'(t_lit[6]),  32'h03);
    check("basic_op9",    32'(t_op[9]),   32'h07);
    check("basic_nexec",  32'(count_exec(1'b0)), 32'd3);
    check("basic_busy11", 32'(t_busy[11]), 32'h1);
    check("basic_done12", 32'(t_done[12]), 32'h1);
    check("basic_busy12", 32'(t_busy[12]), 32'h0);
    check("basic_pc12",   32'(t_pc[12]),   32'h3);
    check("basic_ndone",  32'(count_done(1'b0)), 32'd1);

    // stall cycles 3-5
    run(1'b0, 64'h1, 64'h38, 64'h0);
    check("stall_op3",   32'(t_op[3]), 32'(NOP));
    check("stall_op5",   32'(t_op[5]), 32'(NOP));
    check("stall_lit4",  32'(t_lit[4]), 32'h05);
    check("stall_op6",   32'(t_op[6]), 32'h00);
    check("stall_pc6",   32'(t_pc[6]), 32'h0);
    check("stall_pc7",   32'(t_pc[7]), 32'h1);
    check("stall_op9",   32'(t_op[9]), 32'h01);
    check("stall_done15", 32'(t_done[15]), 32'h1);

    // start pulses in cycles 2, 4 and the DONE cycle 12 are ignored
    run(1'b0, 64'h1015, 64'h0, 64'h0);
    check("sbusy_op9",   32'(t_op[9]), 32'h07);
    check("sbusy_nexec", 32'(count_exec(1'b0)), 32'd3);
    check("sbusy_done12", 32'(t_done[12]), 32'h1);
    check("sbusy_ndone", 32'(count_done(1'b0)), 32'd1);
    check("sbusy_busy14", 32'(t_busy[14]), 32'h0);
    check("sbusy_pc5",   32'(t_pc[5]), 32'h1);

    // reset during EXEC of address 1 (cycle 6), restart in cycle 9
    run(1'b0, 64'h201, 64'h0, 64'h40);
    check("rmid_op6",   32'(t_op[6]),   32'h01);
    check("rmid_pc6",   32'(t_pc[6]),   32'h1);
    check("rmid_op7",   32'(t_op[7]),   32'(NOP));
    check("rmid_busy7", 32'(t_busy[7]), 32'h0);
    check("rmid_pc7",   32'(t_pc[7]),   32'h0);
    check("rmid_lit7",  32'(t_lit[7]),  32'h0);
    check("rmid_op12",  32'(t_op[12]),  32'h00);
    check("rmid_lit12", 32'(t_lit[12]), 32'h05);

    // HALT at address 0
    rom8[0] = 13'h1F00;
    run(1'b0, 64'h1, 64'h0, 64'h0);
    check("halt0_nexec", 32'(count_exec(1'b0)), 32'd0);
    check("halt0_done3", 32'(t_done[3]), 32'h1);
    check("halt0_pc3",   32'(t_pc[3]),   32'h0);
    check("halt0_busy3", 32'(t_busy[3]), 32'h0);

    // 2-bit PC, no HALT: EXEC 3, 6, 9, 12 then DONE 13 with pc held at 3
    run(1'b1, 64'h1, 64'h0, 64'h0);
    check("eor_nexec", 32'(count_exec(1'b1)), 32'd4);
    check("eor_op3",   32'(t2_op[3]),  32'h01);
    check("eor_op12",  32'(t2_op[12]), 32'h04);
    check("eor_done13", 32'(t2_done[13]), 32'h1);
    check("eor_pc13",  32'(t2_pc[13]), 32'h3);
    check("eor_pc16",  32'(t2_pc[16]), 32'h3);
    check("eor_ndone", 32'(count_done(1'b1)), 32'd1);
    check("eor_dut8_quiet", 32'(count_exec(1'b0)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
